// File: rtl/freq_update_seq.sv
// freq_update_seq: periodic update sequencer for the frequency display.
// Samples the measured period, drives an external multi-cycle divider and a
// multi-cycle bin2bcd converter through start/done handshakes guarded by an
// 8-bit watchdog, and latches six digits for the digitron multiplexer.
// Optional feature macro: LZ_BLANK_EN (blank leading zeros of num0..num3).
module freq_update_seq #(
    parameter int NUMER         = 2000000,
    parameter int NUMER_W       = 21,
    parameter int DEN_W         = 10,
    parameter int REFRESH_TICKS = 500,
    parameter int OFFSET        = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1k,
    input  logic [DEN_W-1:0]   period_in,
    output logic               div_start,
    output logic [NUMER_W-1:0] div_numer,
    output logic [DEN_W-1:0]   div_denom,
    input  logic               div_done,
    input  logic [NUMER_W-1:0] div_quot,
    output logic               bcd_start,
    output logic [15:0]        bcd_bin,
    input  logic               bcd_done,
    input  logic [19:0]        bcd_digits,
    output logic [23:0]        disp_digits,
    output logic               disp_upd,
    output logic               err
);

    localparam int                 CNT_W     = (REFRESH_TICKS > 2) ? $clog2(REFRESH_TICKS) : 1;
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(REFRESH_TICKS - 1);
    localparam logic [7:0]         WD_LIMIT  = 8'(TIMEOUT);
    localparam logic [NUMER_W-1:0] OFFS      = NUMER_W'(OFFSET);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_DIV_REQ,
        ST_DIV_WAIT,
        ST_ADJ,
        ST_BCD_REQ,
        ST_BCD_WAIT,
        ST_LATCH,
        ST_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               req_q, req_d;
    logic [7:0]         wd_q, wd_d;
    logic [NUMER_W-1:0] quot_q, quot_d;
    logic [DEN_W-1:0]   div_denom_q, div_denom_d;
    logic [15:0]        bcd_bin_q, bcd_bin_d;
    logic [23:0]        disp_q, disp_d;
    logic               err_q, err_d;

    logic [NUMER_W-1:0] adj_val;
    logic [31:0]        adj_ext;
    logic [23:0]        latch_digits;

    // Refresh tick counter: a wrap produces a one-cycle update request.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        req_d      = 1'b0;
        if (tick_1k) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                req_d      = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    // Quotient minus calibration offset, clamped at zero.
    always_comb begin
        adj_val = (quot_q < OFFS) ? '0 : (quot_q - OFFS);
        adj_ext = 32'(adj_val);
    end

    // Digits as presented to the display, optionally with leading zeros blanked.
    always_comb begin
`ifdef LZ_BLANK_EN
        logic blanking;
        blanking     = 1'b1;
        latch_digits = {bcd_digits, 4'd0};
        // Only num0..num3 may be blanked; num4 always shows so zero reads "0".
        for (int i = 0; i < 4; i++) begin
            if (blanking && (latch_digits[23-4*i -: 4] == 4'd0)) begin
                latch_digits[23-4*i -: 4] = 4'hF;
            end else begin
                blanking = 1'b0;
            end
        end
`else
        latch_digits = {bcd_digits, 4'd0};
`endif
    end

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        quot_d      = quot_q;
        div_denom_d = div_denom_q;
        bcd_bin_d   = bcd_bin_q;
        disp_d      = disp_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_q) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                div_denom_d = period_in;
                state_d     = (period_in == '0) ? ST_ERR : ST_DIV_REQ;
            end
            ST_DIV_REQ: begin
                wd_d    = 8'd0;
                state_d = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                wd_d = wd_q + 8'd1;
                // A done coinciding with the timeout still counts as success.
                if (div_done) begin
                    quot_d  = div_quot;
                    state_d = ST_ADJ;
                end else if (wd_d == WD_LIMIT) begin
                    state_d = ST_ERR;
                end
            end
            ST_ADJ: begin
                if (adj_ext > 32'd65535) begin
                    state_d = ST_ERR;
                end else begin
                    bcd_bin_d = adj_ext[15:0];
                    state_d   = ST_BCD_REQ;
                end
            end
            ST_BCD_REQ: begin
                wd_d    = 8'd0;
                state_d = ST_BCD_WAIT;
            end
            ST_BCD_WAIT: begin
                wd_d = wd_q + 8'd1;
                // Digits are only valid alongside bcd_done, so capture them here;
                // the display register then changes in the same cycle as disp_upd.
                if (bcd_done) begin
                    disp_d  = latch_digits;
                    err_d   = 1'b0;
                    state_d = ST_LATCH;
                end else if (wd_d == WD_LIMIT) begin
                    state_d = ST_ERR;
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            req_q       <= 1'b0;
            wd_q        <= 8'd0;
            quot_q      <= '0;
            div_denom_q <= '0;
            bcd_bin_q   <= 16'd0;
            disp_q      <= 24'h000000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            req_q       <= req_d;
            wd_q        <= wd_d;
            quot_q      <= quot_d;
            div_denom_q <= div_denom_d;
            bcd_bin_q   <= bcd_bin_d;
            disp_q      <= disp_d;
            err_q       <= err_d;
        end
    end

    assign div_start   = (state_q == ST_DIV_REQ);
    assign bcd_start   = (state_q == ST_BCD_REQ);
    assign disp_upd    = (state_q == ST_LATCH);
    assign div_numer   = NUMER_W'(NUMER);
    assign div_denom   = div_denom_q;
    assign bcd_bin     = bcd_bin_q;
    assign disp_digits = disp_q;
    assign err         = err_q;

endmodule

// File: tb/tb_freq_update_seq.sv
// tb_freq_update_seq: scoreboard bench for freq_update_seq with behavioural
// divider and bin2bcd responders and directed update scenarios.
module tb_freq_update_seq;

    localparam int NUMER_W = 21;
    localparam int DEN_W   = 10;

`ifdef LZ_BLANK_EN
    localparam logic [23:0] D1998 = 24'hF19980;
    localparam logic [23:0] D3998 = 24'hF39980;
    localparam logic [23:0] D0000 = 24'hFFFF00;
`else
    localparam logic [23:0] D1998 = 24'h019980;
    localparam logic [23:0] D3998 = 24'h039980;
    localparam logic [23:0] D0000 = 24'h000000;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               tick_1k;
    logic [DEN_W-1:0]   period_in;
    logic               div_start;
    logic [NUMER_W-1:0] div_numer;
    logic [DEN_W-1:0]   div_denom;
    logic               div_done;
    logic [NUMER_W-1:0] div_quot;
    logic               bcd_start;
    logic [15:0]        bcd_bin;
    logic               bcd_done;
    logic [19:0]        bcd_digits;
    logic [23:0]        disp_digits;
    logic               disp_upd;
    logic               err;

    freq_update_seq #(
        .NUMER(2000000), .NUMER_W(NUMER_W), .DEN_W(DEN_W),
        .REFRESH_TICKS(4), .OFFSET(2), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .tick_1k(tick_1k), .period_in(period_in),
        .div_start(div_start), .div_numer(div_numer), .div_denom(div_denom),
        .div_done(div_done), .div_quot(div_quot),
        .bcd_start(bcd_start), .bcd_bin(bcd_bin), .bcd_done(bcd_done),
        .bcd_digits(bcd_digits), .disp_digits(disp_digits),
        .disp_upd(disp_upd), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder configuration and observation counters.
    bit                 div_answer = 1'b1;
    int                 div_lat    = 20;
    int                 bcd_lat    = 17;
    logic [NUMER_W-1:0] div_q_cfg  = '0;
    int                 n_div_start = 0;
    int                 n_bcd_start = 0;
    int                 n_upd       = 0;
    int                 last_upd_cyc = 0;
    int                 div_start_cyc = 0;
    int                 tick_cyc = 0;

    logic [15:0] exp_bin[$];
    logic [23:0] exp_disp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Four tick_1k pulses wrap the counter once and request one update.
    task automatic do_update();
        for (int i = 0; i < 4; i++) begin
            tick_1k  = 1'b1;
            tick_cyc = cyc;
            step(1);
            tick_1k = 1'b0;
            step(1);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Divider model: answers div_q_cfg div_lat cycles after div_start.
    initial begin
        div_done = 1'b0;
        div_quot = '0;
        forever begin
            step(1);
            if (div_start) begin
                n_div_start++;
                div_start_cyc = cyc;
                if (div_answer) begin
                    step(div_lat);
                    div_quot = div_q_cfg;
                    div_done = 1'b1;
                    step(1);
                    div_done = 1'b0;
                end
            end
        end
    end

    // Converter model: answers with the BCD of bcd_bin bcd_lat cycles after bcd_start.
    initial begin
        bcd_done   = 1'b0;
        bcd_digits = '0;
        forever begin
            step(1);
            if (bcd_start) begin
                int v;
                v = int'(bcd_bin);
                step(bcd_lat);
                bcd_digits = to_bcd(v);
                bcd_done   = 1'b1;
                step(1);
                bcd_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: pops an expectation whenever the DUT presents output.
    initial begin
        forever begin
            step(1);
            if (bcd_start) begin
                n_bcd_start++;
                if (exp_bin.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_bcd_start: bcd_bin=0x%0h, none expected", bcd_bin);
                end else begin
                    check("bcd_bin", 32'(bcd_bin), 32'(exp_bin.pop_front()));
                end
            end
            if (disp_upd) begin
                n_upd++;
                last_upd_cyc = cyc;
                if (exp_disp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_disp_upd: disp_digits=0x%0h, none expected", disp_digits);
                end else begin
                    check("disp_digits", 32'(disp_digits), 32'(exp_disp.pop_front()));
                end
            end
        end
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "time limit");
    end

    initial begin
        int nd, nb, nu, s, i;
        rst       = 1'b1;
        tick_1k   = 1'b0;
        period_in = '0;
        step(3);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_bcd_start", 32'(bcd_start), 32'd0);
        check("rst_div_denom", 32'(div_denom), 32'd0);
        check("rst_bcd_bin", 32'(bcd_bin), 32'd0);
        check("rst_disp_digits", 32'(disp_digits), 32'h000000);
        check("rst_disp_upd", 32'(disp_upd), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("div_numer", 32'(div_numer), 32'd2000000);
        rst = 1'b0;
        step(2);

        // T1: nominal update, 1000 -> q=2000 -> 1998
        period_in = 10'd1000;
        div_q_cfg = 21'd2000;
        div_lat   = 20;
        bcd_lat   = 17;
        nd = n_div_start;
        nu = n_upd;
        exp_bin.push_back(16'd1998);
        exp_disp.push_back(D1998);
        do_update();
        step(80);
        check("t1_div_starts", 32'(n_div_start - nd), 32'd1);
        check("t1_upd_count", 32'(n_upd - nu), 32'd1);
        check("t1_latency", 32'(last_upd_cyc - tick_cyc), 32'(6 + 20 + 17));
        check("t1_div_denom", 32'(div_denom), 32'd1000);
        check("t1_err", 32'(err), 32'd0);

        // T2: zero period -> error, display held; then recovery with 500
        period_in = 10'd0;
        nd = n_div_start;
        do_update();
        step(20);
        check("t2_no_div_start", 32'(n_div_start - nd), 32'd0);
        check("t2_err", 32'(err), 32'd1);
        check("t2_disp_held", 32'(disp_digits), 32'(D1998));
        check("t2_div_denom", 32'(div_denom), 32'd0);
        period_in = 10'd500;
        div_q_cfg = 21'd4000;
        exp_bin.push_back(16'd3998);
        exp_disp.push_back(D3998);
        do_update();
        step(80);
        check("t2_recover_err", 32'(err), 32'd0);

        // T3: divider silent -> watchdog error; late done ignored; then normal
        div_answer = 1'b0;
        period_in  = 10'd1000;
        nd = n_div_start;
        do_update();
        for (i = 0; i < 50 && n_div_start == nd; i++) step(1);
        if (n_div_start == nd) begin
            n_tests++;
            n_fail++;
            $display("FAIL t3_div_start_wait: got no div_start, required one within 50 cycles");
        end
        s = div_start_cyc;
        step(s + 250 - cyc);
        check("t3_err_before_timeout", 32'(err), 32'd0);
        step(12);
        check("t3_err_after_timeout", 32'(err), 32'd1);
        nu = n_upd;
        div_quot = 21'd2000;
        div_done = 1'b1;
        step(1);
        div_done = 1'b0;
        step(20);
        check("t3_late_done_ignored", 32'(n_upd - nu), 32'd0);
        check("t3_late_err_kept", 32'(err), 32'd1);
        div_answer = 1'b1;
        div_q_cfg  = 21'd2000;
        exp_bin.push_back(16'd1998);
        exp_disp.push_back(D1998);
        do_update();
        step(80);
        check("t3_recover_err", 32'(err), 32'd0);

        // T4: q below offset clamps to zero
        div_q_cfg = 21'd1;
        exp_bin.push_back(16'd0);
        exp_disp.push_back(D0000);
        do_update();
        step(80);
        check("t4_err", 32'(err), 32'd0);

        // T5: value above 16 bits -> error, no conversion
        period_in = 10'd1;
        div_q_cfg = 21'd2000000;
        nb = n_bcd_start;
        do_update();
        step(60);
        check("t5_err", 32'(err), 32'd1);
        check("t5_no_bcd_start", 32'(n_bcd_start - nb), 32'd0);
        check("t5_disp_held", 32'(disp_digits), 32'(D0000));

        // T6: reset while waiting on the converter
        period_in = 10'd1000;
        div_q_cfg = 21'd2000;
        bcd_lat   = 30;
        nb = n_bcd_start;
        exp_bin.push_back(16'd1998);
        do_update();
        for (i = 0; i < 200 && n_bcd_start == nb; i++) step(1);
        if (n_bcd_start == nb) begin
            n_tests++;
            n_fail++;
            $display("FAIL t6_bcd_start_wait: got no bcd_start, required one within 200 cycles");
        end
        step(3);
        rst = 1'b1;
        step(1);
        check("t6_div_start", 32'(div_start), 32'd0);
        check("t6_bcd_start", 32'(bcd_start), 32'd0);
        check("t6_div_denom", 32'(div_denom), 32'd0);
        check("t6_bcd_bin", 32'(bcd_bin), 32'd0);
        check("t6_disp_digits", 32'(disp_digits), 32'h000000);
        check("t6_disp_upd", 32'(disp_upd), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        rst = 1'b0;
        nu = n_upd;
        step(50);
        check("t6_no_update", 32'(n_upd - nu), 32'd0);
        check("t6_disp_still_zero", 32'(disp_digits), 32'h000000);

        check("bin_queue_drained", 32'(exp_bin.size()), 32'd0);
        check("disp_queue_drained", 32'(exp_disp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
